// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a multicycle RV32-style datapath. It sequences
// fetch, decode, address generation, memory access, execute and writeback.
// Outputs are decoded from the current state only. The exception is the
// instruction-fetch enables, which also wait for mem_ready.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   opcode_in    instruction register bits [6:0] (used in DECODE/MEMADR)
//   mem_ready    memory completion for FETCH, MEMRD and MEMWR
//   ALUop_out    ALU class: 00 add, 01 sub/compare, 10 use func fields
//   ALUSrcA, ALUSrcB, PCSource, MemtoReg           datapath mux selects
//   PCWrite, PCWriteCond, IRWrite, MemRead,
//   MemWrite, RegWrite                             datapath enables
//   illegal_op   one-cycle registered pulse for an unsupported opcode
//   state_out    current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode_in,
    input  logic               mem_ready,
    output logic [1:0]         ALUop_out,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               PCSource,
    output logic               MemtoReg,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [3:0] state;
    logic [3:0] state_next;
    logic       op_supported;

    assign op_supported = (opcode_in == OP_RTYPE) || (opcode_in == OP_LOAD) ||
                          (opcode_in == OP_STORE) || (opcode_in == OP_BEQ);

    assign state_out = STATE_W'(state);

    // State register. Reset lands directly in FETCH, so the decoded outputs
    // show the FETCH values while reset is held. Any instruction in flight
    // is dropped before it can write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_next;
            illegal_op <= (state == DECODE) && !op_supported;
        end
    end

    // Next-state logic. The opcode is only consulted in DECODE and MEMADR.
    // Unused encodings fall back to FETCH.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode_in == OP_LOAD || opcode_in == OP_STORE)
                    state_next = MEMADR;
                else if (opcode_in == OP_RTYPE)
                    state_next = EXEC;
                else if (opcode_in == OP_BEQ)
                    state_next = BRANCH;
                else
                    state_next = FETCH;
            end
            MEMADR: begin
                if (opcode_in == OP_LOAD)
                    state_next = MEMRD;
                else if (opcode_in == OP_STORE)
                    state_next = MEMWR;
                else
                    state_next = FETCH;
            end
            MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_next = FETCH;
            MEMWR:   state_next = mem_ready ? FETCH : MEMWR;
            EXEC:    state_next = ALUWB;
            ALUWB:   state_next = FETCH;
            BRANCH:  state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Output decode. Every signal defaults to 0. Each state then raises only
    // the controls it uses. ALUop_out is never driven to 11.
    always_comb begin
        ALUop_out   = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 1'b0;
        MemtoReg    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b10;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUop_out = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop_out   = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Inputs change on the falling clock
// edge, and outputs are sampled 1 time unit later. Each expected value is a
// hand-derived constant.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode_in;
    logic       mem_ready;
    logic [1:0] ALUop_out;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCSource;
    logic       MemtoReg;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       illegal_op;
    logic [3:0] state_out;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.STATE_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode_in   (opcode_in),
        .mem_ready   (mem_ready),
        .ALUop_out   (ALUop_out),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .MemtoReg    (MemtoReg),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .illegal_op  (illegal_op),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Moves to the next falling edge, drives the inputs, then waits 1 unit
    // before any checks are made.
    task automatic apply_stimulus(input logic ready, input logic [6:0] op);
        @(negedge clk);
        mem_ready = ready;
        opcode_in = op;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode_in = 7'd0;
        #2;
        check_output("reset_state", state_out, 0);
        check_output("reset_illegal", illegal_op, 0);
        check_output("reset_memread", MemRead, 1);
        check_output("reset_alusrcb", ALUSrcB, 2'b01);
        check_output("reset_irwrite", IRWrite, 0);
        check_output("reset_regwrite", RegWrite, 0);

        // R-type: 0,1,6,7,0. The opcode changes in EXEC and must be ignored.
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        opcode_in = OP_RTYPE;
        #1;
        check_output("r_fetch_state", state_out, 0);
        check_output("r_fetch_irwrite", IRWrite, 1);
        check_output("r_fetch_pcwrite", PCWrite, 1);
        apply_stimulus(1'b1, OP_RTYPE);
        check_output("r_decode_state", state_out, 1);
        check_output("r_decode_alusrcb", ALUSrcB, 2'b10);
        apply_stimulus(1'b1, OP_STORE);
        check_output("r_exec_state", state_out, 6);
        check_output("r_exec_aluop", ALUop_out, 2'b10);
        check_output("r_exec_alusrca", ALUSrcA, 1);
        check_output("r_exec_regwrite", RegWrite, 0);
        apply_stimulus(1'b1, OP_STORE);
        check_output("r_aluwb_state", state_out, 7);
        check_output("r_aluwb_regwrite", RegWrite, 1);
        check_output("r_aluwb_memtoreg", MemtoReg, 0);
        apply_stimulus(1'b0, OP_LOAD);
        check_output("r_done_state", state_out, 0);

        // FETCH stall: mem_ready is low for 3 cycles, then high.
        check_output("stall0_irwrite", IRWrite, 0);
        check_output("stall0_pcwrite", PCWrite, 0);
        apply_stimulus(1'b0, OP_LOAD);
        check_output("stall1_state", state_out, 0);
        check_output("stall1_irwrite", IRWrite, 0);
        apply_stimulus(1'b0, OP_LOAD);
        check_output("stall2_state", state_out, 0);
        check_output("stall2_pcwrite", PCWrite, 0);
        apply_stimulus(1'b1, OP_LOAD);
        check_output("stall_rel_state", state_out, 0);
        check_output("stall_rel_irwrite", IRWrite, 1);
        check_output("stall_rel_pcwrite", PCWrite, 1);

        // LOAD with two MEMRD wait cycles: 0,1,2,3,3,3,4,0.
        apply_stimulus(1'b1, OP_LOAD);
        check_output("ld_decode_state", state_out, 1);
        check_output("ld_decode_irwrite", IRWrite, 0);
        apply_stimulus(1'b0, OP_LOAD);
        check_output("ld_memadr_state", state_out, 2);
        check_output("ld_memadr_alusrca", ALUSrcA, 1);
        check_output("ld_memadr_alusrcb", ALUSrcB, 2'b10);
        apply_stimulus(1'b0, OP_LOAD);
        check_output("ld_memrd_w1_state", state_out, 3);
        check_output("ld_memrd_memread", MemRead, 1);
        apply_stimulus(1'b0, OP_LOAD);
        check_output("ld_memrd_w2_state", state_out, 3);
        apply_stimulus(1'b1, OP_LOAD);
        check_output("ld_memrd_rdy_state", state_out, 3);
        check_output("ld_memrd_regwrite", RegWrite, 0);
        apply_stimulus(1'b1, OP_LOAD);
        check_output("ld_memwb_state", state_out, 4);
        check_output("ld_memwb_regwrite", RegWrite, 1);
        check_output("ld_memwb_memtoreg", MemtoReg, 1);
        apply_stimulus(1'b1, OP_BEQ);
        check_output("ld_done_state", state_out, 0);

        // BEQ: 0,1,8,0.
        apply_stimulus(1'b1, OP_BEQ);
        check_output("beq_decode_state", state_out, 1);
        apply_stimulus(1'b1, OP_BEQ);
        check_output("beq_branch_state", state_out, 8);
        check_output("beq_aluop", ALUop_out, 2'b01);
        check_output("beq_pcwritecond", PCWriteCond, 1);
        check_output("beq_pcsource", PCSource, 1);
        apply_stimulus(1'b1, OP_BAD);
        check_output("beq_done_state", state_out, 0);

        // Illegal opcode: 0,1,0 with a single-cycle illegal_op pulse.
        apply_stimulus(1'b0, OP_BAD);
        check_output("ill_decode_state", state_out, 1);
        check_output("ill_decode_flag", illegal_op, 0);
        apply_stimulus(1'b0, OP_BAD);
        check_output("ill_back_state", state_out, 0);
        check_output("ill_pulse", illegal_op, 1);
        check_output("ill_regwrite", RegWrite, 0);
        check_output("ill_memwrite", MemWrite, 0);
        apply_stimulus(1'b1, OP_STORE);
        check_output("ill_pulse_end", illegal_op, 0);
        check_output("ill_hold_state", state_out, 0);

        // STORE, with an asynchronous reset applied during the MEMWR wait.
        apply_stimulus(1'b1, OP_STORE);
        check_output("st_decode_state", state_out, 1);
        apply_stimulus(1'b0, OP_STORE);
        check_output("st_memadr_state", state_out, 2);
        apply_stimulus(1'b0, OP_STORE);
        check_output("st_memwr_state", state_out, 5);
        check_output("st_memwr_memwrite", MemWrite, 1);
        apply_stimulus(1'b0, OP_STORE);
        check_output("st_memwr_wait_state", state_out, 5);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_state", state_out, 0);
        check_output("async_rst_memwrite", MemWrite, 0);
        check_output("async_rst_memread", MemRead, 1);
        apply_stimulus(1'b1, OP_STORE);
        check_output("rst_hold_state", state_out, 0);
        check_output("rst_hold_regwrite", RegWrite, 0);

        // Reset release: the first rising edge moves the FSM to DECODE.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("rel_state", state_out, 0);
        apply_stimulus(1'b1, OP_STORE);
        check_output("rel_first_edge_state", state_out, 1);

        $display("[TB] directed sequence complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the parameter STATE_W, default 4, which is the width of the state debug output.
REQ-002 Port clk  input  1  The single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 Port opcode_in  input  7  The instruction register bits [6:0]; they are valid from the DECODE state onward.
REQ-005 Port mem_ready  input  1  Memory completion; it SHALL qualify the FETCH, MEMRD and MEMWR states.
REQ-006 Port ALUop_out  output  2  The ALU operation class for the downstream ALU control decoder: 00 = add, 01 = subtract/compare, 10 = use func7/func3.
REQ-007 Ports ALUSrcA (1b), ALUSrcB (2b), PCSource (1b), MemtoReg (1b)  outputs  These are the datapath mux selects.
REQ-008 Ports PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite  outputs  1b each  These are the datapath enables.
REQ-009 Port illegal_op  output  1  A one-cycle pulse that flags an unsupported opcode.
REQ-010 Port state_out  output  STATE_W  The current state encoding, for debug.

Function
REQ-011 The block SHALL implement a registered FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8.
REQ-012 The supported opcodes SHALL be: R-type 0110011, LOAD 0000011, STORE 0100011, BEQ 1100011.
REQ-013 FETCH transitions:
- mem_ready=1: go to DECODE.
- mem_ready=0: stay in FETCH.
REQ-014 DECODE transitions:
- LOAD or STORE: go to MEMADR.
- R-type: go to EXEC.
- BEQ: go to BRANCH.
- Any other opcode: go to FETCH.
REQ-015 MEMADR SHALL go to MEMRD for LOAD and to MEMWR for STORE.
REQ-016 MEMRD SHALL go to MEMWB when mem_ready=1 and otherwise stay in MEMRD.
REQ-017 MEMWR SHALL go to FETCH when mem_ready=1 and otherwise stay in MEMWR.
REQ-018 MEMWB, ALUWB and BRANCH SHALL each go to FETCH unconditionally.
REQ-019 EXEC SHALL go to ALUWB unconditionally.
REQ-020 Outputs SHALL be combinational from the current state, except that IRWrite and PCWrite SHALL be ANDed with mem_ready. Any output not listed for a state SHALL be 0.
REQ-021 Output table:
- FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUop_out=00, IRWrite=mem_ready, PCWrite=mem_ready, PCSource=0.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUop_out=00 (branch-target precompute).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop_out=00.
- MEMRD: MemRead=1.
- MEMWB: RegWrite=1, MemtoReg=1.
- MEMWR: MemWrite=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop_out=10.
- ALUWB: RegWrite=1, MemtoReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop_out=01, PCWriteCond=1, PCSource=1.
REQ-022 ALUop_out=11 SHALL never be driven.
REQ-023 illegal_op SHALL be a registered output, asserted for exactly the one cycle after a DECODE cycle that saw an unsupported opcode, coincident with the return to FETCH.
REQ-024 Instruction latencies, in cycles with zero memory wait:
- R-type: 4.
- LOAD: 5.
- STORE: 4.
- BEQ: 3.
Each memory-wait cycle SHALL add exactly one cycle.
REQ-025 opcode_in SHALL be ignored in every state except DECODE and MEMADR.
REQ-026 An undefined state encoding SHALL transition to FETCH on the next edge.

Reset
REQ-027 rst_n=0 SHALL force state=FETCH and illegal_op=0 immediately, with no wait for a clock edge.
REQ-028 During reset, the combinational outputs SHALL be the FETCH values.
REQ-029 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction without issuing any further RegWrite or MemWrite.
REQ-030 The first state transition after reset release SHALL occur on the first rising clk edge with rst_n=1.

Verification
REQ-031 R-type: opcode 0110011, mem_ready=1 -> state sequence 0,1,6,7,0; ALUop_out=10 in state 6; RegWrite=1 only in state 7.
REQ-032 LOAD with 2 wait cycles in MEMRD: opcode 0000011, mem_ready=0 for 2 cycles -> sequence 0,1,2,3,3,3,4,0; MemtoReg=1 with RegWrite=1 in state 4.
REQ-033 FETCH stall: mem_ready=0 for 3 cycles -> state held at 0; IRWrite=0 and PCWrite=0 until mem_ready=1, then both are 1 for one cycle.
REQ-034 BEQ: opcode 1100011 -> sequence 0,1,8,0; ALUop_out=01 and PCWriteCond=1 in state 8.
REQ-035 Illegal opcode: opcode 1111111 -> sequence 0,1,0; illegal_op=1 for exactly one cycle; no RegWrite or MemWrite.
REQ-036 Asynchronous reset: rst_n driven 0 mid-cycle while in MEMWR -> state_out=0 and MemWrite=0 before the next clk edge.
